update_compactor: RTL
=====================

Name: update_compactor

Overview:
- Sits directly upstream of the 8-lane update packer.
- Accepts 8-lane, 64-bit update bundles whose valid mask may be sparse (any of 256 patterns).
- Left-compacts the valid updates toward the MSB lane and emits a prefix-form mask (8'b1..10..0), which is the only form the packer coalesces.
- Sequences the end-of-stream marker so it always arrives at the packer in its own cycle, after the final data.

Parameters:
- W, 64, width of one update word.
- N, 8, lane count; fixed at 8 because the packer is 8-wide; any other value is rejected at elaboration.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- word_in  in  W*N  lane k occupies bits [W*(N-k)-1 : W*(N-k-1)]; lane 0 = [511:448].
- word_in_valid  in  N  bit (N-1-k) marks lane k valid (bit 7 = lane 0).
- last_input_in  in  1  end of stream; may coincide with data.
- in_ready  out  1  upstream may present data/last only when high.
- word_out  out  W*N  compacted lanes; invalid lanes are zero.
- valid_out  out  N  prefix mask; popcount equals the input popcount.
- last_input_out  out  1  one-cycle end-of-stream pulse to the packer.
- upd_count  out  32  total valid updates accepted since reset; wraps.

Behaviour:
- Reset (rst=0 at posedge):
  - word_out=0, valid_out=0, last_input_out=0, in_ready=1, upd_count=0.
  - All pipeline valids and the last-pending flag cleared.
  - A bundle that is in flight when reset asserts is discarded.
- Acceptance: an input is accepted when in_ready=1 and (word_in_valid!=0 or last_input_in=1). Inputs presented while in_ready=0 are ignored and are a protocol violation.
- Stage 1 (S1), registered:
  - Capture the data and mask.
  - Compute an exclusive prefix count pos[k] (3 bits) of valid lanes preceding lane k, in lane order 0..7.
  - Compute popcount cnt (4 bits, 0..8).
  - Capture the last flag.
- Stage 2 (S2), registered output:
  - For each output slot j, word_out slot j = the data of the valid lane k with pos[k]==j.
  - Slot j is zero if no such lane exists.
  - valid_out = N-bit mask with the top cnt bits set (cnt=8 gives 8'hFF; cnt=0 gives 8'h00).
- Latency: data accepted at cycle T appears on word_out/valid_out at T+2. Throughput is 1 bundle/cycle.
- Order is preserved within a bundle (ascending lane index maps to ascending slot) and across bundles.
- Mask 0 with no last: not accepted as a bundle; no output; S1 is bubbled.
- Last without data (mask 0): last_input_out=1 at T+2 with valid_out=0 and word_out=0.
- Last with data (mask!=0) accepted at T:
  - Data emits at T+2 with last_input_out=0.
  - last_input_out=1 at T+3 with valid_out=0.
  - in_ready=0 during cycle T+1 only, so no bundle can collide with the T+3 last slot.
  - in_ready returns to 1 at T+2.
- Idle cycles: valid_out=0, word_out=0, last_input_out=0.
- upd_count:
  - Adds cnt when the bundle leaves S1.
  - 32-bit wrap from 0xFFFFFFFF to 0x00000000 with no flag.
- Back-to-back lasts (each with data) are legal. Each costs one bubble cycle.

Decomposition:
- Shared package holds:
  - W and N constants.
  - popcount8 and prefix_mask(cnt) functions, reused by the packer's testbench.
  - The lane-slice index helper.
- One sub-module is natural: lane_prefix_count. It is combinational: mask in, pos[0..7] and cnt out, and is instantiated in S1.
- The S2 scatter and the last sequencer stay in the top level.

Test Plan:
- Mask 8'b10100101, lanes 0..7 = A..H -> at T+2 word_out slots 0..3 = A,C,F,H, slots 4..7 = 0, valid_out=8'b11110000; upd_count +4.
- Masks 8'hFF then 8'h01 then 8'h80 on consecutive cycles -> valid_out sequence 8'hFF, 8'h80, 8'h80 on T+2..T+4; the 8'h01 bundle yields lane 7's data in slot 0.
- Mask 8'b01000001 with last_input_in=1 at T -> in_ready=0 at T+1; at T+2 valid_out=8'b11000000, last_input_out=0; at T+3 last_input_out=1, valid_out=0.
- last_input_in=1 with mask 0 -> at T+2 last_input_out=1, valid_out=0; in_ready stays 1.
- Stream of 8'hFF bundles; rst=0 asserted for one cycle mid-stream -> next cycle all outputs 0 and upd_count=0; the two in-flight bundles are never emitted.
- Preload upd_count to 0xFFFFFFFE (force) then send mask 8'b11100000 -> upd_count = 0x00000001.

Source files
------------

// File: rtl/update_compactor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : update_compactor_pkg
// Description : Shared constants, types and helpers for the update compactor
//               and the downstream 8-lane packer bench.
// Revision    : 1.0 - initial release
// ============================================================================
package update_compactor_pkg;

  localparam int unsigned W = 64;  // width of one update word
  localparam int unsigned N = 8;   // lane count, fixed by the packer

  typedef logic [2:0] pos_t;       // exclusive prefix position 0..7
  typedef logic [3:0] cnt_t;       // popcount 0..8

  // Number of set bits in an 8-bit lane mask.
  function automatic cnt_t popcount8(input logic [7:0] m);
    cnt_t c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, m[i]};
    end
    return c;
  endfunction

  // Prefix-form mask with the top cnt bits set (0 -> 8'h00, 8 -> 8'hFF).
  function automatic logic [7:0] prefix_mask(input cnt_t c);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (cnt_t'(i) < c) begin
        m[7-i] = 1'b1;
      end
    end
    return m;
  endfunction

  // LSB index of lane k inside the packed W*N bus (lane 0 sits at the top).
  function automatic int unsigned lane_lsb(input int unsigned k);
    return W * (N - 1 - k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/update_compactor_if.sv
`default_nettype none
// ============================================================================
// Module      : update_compactor_if
// Description : Bundle bus between the upstream producer, the compactor and
//               the packer. master = producer/observer side, slave = compactor.
// Revision    : 1.0 - initial release
// ============================================================================
interface update_compactor_if;
  import update_compactor_pkg::*;

  logic [W*N-1:0] word_in;
  logic [N-1:0]   word_in_valid;
  logic           last_input_in;
  logic           in_ready;
  logic [W*N-1:0] word_out;
  logic [N-1:0]   valid_out;
  logic           last_input_out;
  logic [31:0]    upd_count;

  modport master (
    output word_in, word_in_valid, last_input_in,
    input  in_ready, word_out, valid_out, last_input_out, upd_count
  );

  modport slave (
    input  word_in, word_in_valid, last_input_in,
    output in_ready, word_out, valid_out, last_input_out, upd_count
  );

endinterface
`default_nettype wire

// File: rtl/update_compactor_lane_prefix_count.sv
`default_nettype none
// ============================================================================
// Module      : update_compactor_lane_prefix_count
// Description : Combinational exclusive prefix count of valid lanes (lane
//               order 0..7) plus total popcount of the mask.
// Revision    : 1.0 - initial release
// ============================================================================
module update_compactor_lane_prefix_count
  import update_compactor_pkg::*;
(
  input  logic [N-1:0]       mask,   // bit (N-1-k) = lane k
  output pos_t [N-1:0]       pos,    // pos[k] = valid lanes before lane k
  output cnt_t               cnt
);

  // Running sum walks lanes in order; each lane sees the count before it.
  always_comb begin
    cnt_t acc;
    acc = '0;
    pos = '0;
    for (int k = 0; k < N; k++) begin
      pos[k] = acc[2:0];
      acc    = acc + {3'b000, mask[N-1-k]};
    end
    cnt = acc;
  end

endmodule
`default_nettype wire

// File: rtl/update_compactor.sv
`default_nettype none
// ============================================================================
// Module      : update_compactor
// Description : Two-stage left-compactor for sparse 8-lane update bundles.
//               S1 captures data and computes lane positions; S2 scatters
//               valid lanes into a prefix-form output and sequences the
//               end-of-stream pulse into its own cycle after the final data.
// Revision    : 1.0 - initial release
// ============================================================================
module update_compactor #(
  parameter int unsigned W = update_compactor_pkg::W,
  parameter int unsigned N = update_compactor_pkg::N
) (
  input  logic                 clk,
  input  logic                 rst,   // synchronous, active-low
  update_compactor_if.slave    bus
);
  import update_compactor_pkg::*;

  // The packer is exactly 8 lanes of 64 bits; nothing else is supported.
  if (N != 8 || W != update_compactor_pkg::W) begin : g_bad_geometry
    $error("update_compactor: only N=8, W=64 is supported");
  end

  // ---------------- S1 state ----------------
  logic           s1_valid_q, s1_valid_d;
  logic           s1_last_q,  s1_last_d;
  logic [W*N-1:0] s1_data_q,  s1_data_d;
  logic [N-1:0]   s1_mask_q,  s1_mask_d;
  pos_t [N-1:0]   s1_pos_q,   s1_pos_d;
  cnt_t           s1_cnt_q,   s1_cnt_d;

  // ---------------- S2 / output state ----------------
  logic [W*N-1:0] word_out_q, word_out_d;
  logic [N-1:0]   valid_out_q, valid_out_d;
  logic           last_out_q, last_out_d;
  logic           pend_last_q, pend_last_d;
  logic [31:0]    upd_count_q, upd_count_d;

  pos_t [N-1:0]   w_pos;
  cnt_t           w_cnt;
  logic           w_accept;
  logic           w_ready;

  update_compactor_lane_prefix_count u_prefix (
    .mask (bus.word_in_valid),
    .pos  (w_pos),
    .cnt  (w_cnt)
  );

  // A data-carrying last in S1 blocks intake for one cycle so the trailing
  // last pulse gets its own output slot with nothing colliding behind it.
  assign w_ready  = !(s1_valid_q && s1_last_q && (s1_cnt_q != 4'd0));
  assign w_accept = w_ready && ((|bus.word_in_valid) || bus.last_input_in);

  // S1 next state: capture an accepted bundle, otherwise bubble.
  always_comb begin
    s1_valid_d = w_accept;
    s1_last_d  = w_accept && bus.last_input_in;
    s1_data_d  = s1_data_q;
    s1_mask_d  = s1_mask_q;
    s1_pos_d   = s1_pos_q;
    s1_cnt_d   = s1_cnt_q;
    if (w_accept) begin
      s1_data_d = bus.word_in;
      s1_mask_d = bus.word_in_valid;
      s1_pos_d  = w_pos;
      s1_cnt_d  = w_cnt;
    end
  end

  // S2 next state: scatter valid lanes to their slots and sequence last.
  always_comb begin
    word_out_d  = '0;
    valid_out_d = '0;
    last_out_d  = 1'b0;
    pend_last_d = 1'b0;
    upd_count_d = upd_count_q;
    if (s1_valid_q) begin
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < N; k++) begin
          if (s1_mask_q[N-1-k] && (s1_pos_q[k] == pos_t'(j))) begin
            word_out_d[lane_lsb(j) +: W] = word_out_d[lane_lsb(j) +: W]
                                         | s1_data_q[lane_lsb(k) +: W];
          end
        end
      end
      valid_out_d = prefix_mask(s1_cnt_q);
      upd_count_d = upd_count_q + {28'd0, s1_cnt_q};
      if (s1_last_q) begin
        if (s1_cnt_q == 4'd0) begin
          last_out_d = 1'b1;
        end else begin
          pend_last_d = 1'b1;
        end
      end
    end
    if (pend_last_q) begin
      last_out_d = 1'b1;
    end
  end

  // Pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_data_q   <= '0;
      s1_mask_q   <= '0;
      s1_pos_q    <= '0;
      s1_cnt_q    <= '0;
      word_out_q  <= '0;
      valid_out_q <= '0;
      last_out_q  <= 1'b0;
      pend_last_q <= 1'b0;
      upd_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_data_q   <= s1_data_d;
      s1_mask_q   <= s1_mask_d;
      s1_pos_q    <= s1_pos_d;
      s1_cnt_q    <= s1_cnt_d;
      word_out_q  <= word_out_d;
      valid_out_q <= valid_out_d;
      last_out_q  <= last_out_d;
      pend_last_q <= pend_last_d;
      upd_count_q <= upd_count_d;
    end
  end

  assign bus.in_ready       = w_ready;
  assign bus.word_out       = word_out_q;
  assign bus.valid_out      = valid_out_q;
  assign bus.last_input_out = last_out_q;
  assign bus.upd_count      = upd_count_q;

endmodule
`default_nettype wire
